tx_frame_ctrl: RTL and testbench

TX_FRAME_CTRL -- requirements
Module: tx_frame_ctrl

---
 rtl/tx_pkg.sv | 22 ++
 rtl/tx_fifo.sv | 72 +++++++
 rtl/tx_frame_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the UART transmit frame controller: state encodings,
// data width, stop-bit limits and the parity helper.
package tx_pkg;

    localparam int DATA_BITS     = 8;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } tx_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the transmitter; pointers carry an extra wrap bit and the
// read data is registered, valid the cycle after a pop.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      wr_ptr_nx_s;
    logic [AW:0]      rd_ptr_nx_s;
    logic [WIDTH-1:0] dout_r;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;

    // Next pointer values; flags are derived from them so they can be registered.
    always_comb begin
        wr_ptr_nx_s = wr_ptr_r + {{AW{1'b0}}, push_ok_s};
        rd_ptr_nx_s = rd_ptr_r + {{AW{1'b0}}, pop_ok_s};
    end

    // Pointer, flag and read-data registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            dout_r   <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            full_r   <= (wr_ptr_nx_s[AW] != rd_ptr_nx_s[AW]) &&
                        (wr_ptr_nx_s[AW-1:0] == rd_ptr_nx_s[AW-1:0]);
            empty_r  <= (wr_ptr_nx_s == rd_ptr_nx_s);
            if (pop_ok_s) begin
                dout_r <= mem_r[rd_ptr_r[AW-1:0]];
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    assign dout  = dout_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/tx_frame_ctrl.sv
// UART transmit frame controller: FIFO-buffered bytes framed as start/8 data/stop.
// Define TX_PARITY_EN to insert an even-parity bit between data and stop.
module tx_frame_ctrl
    import tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       TX_En,
    input  logic [7:0] TX_Data,
    output logic       TX_Rdy,
    output logic       TX_Ovf,
    input  logic       BPS_CLK,
    output logic       Count_Sig,
    output logic       TX_Pin_Out,
    output logic       TX_Busy,
    output logic       TX_Done
);

    localparam int STOP_N = (STOP_BITS > STOP_BITS_MAX) ? STOP_BITS_MAX :
                            (STOP_BITS < STOP_BITS_MIN) ? STOP_BITS_MIN : STOP_BITS;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [0:0] LAST_STOP = 1'(STOP_N - 1);

    tx_state_e            state_r;
    tx_state_e            state_nx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_nx_s;
    logic [2:0]           bit_cnt_r;
    logic [2:0]           bit_cnt_nx_s;
    logic [0:0]           stop_cnt_r;
    logic [0:0]           stop_cnt_nx_s;
`ifdef TX_PARITY_EN
    logic                 parity_r;
    logic                 parity_nx_s;
`endif
    logic                 pin_r;
    logic                 pin_nx_s;
    logic                 cs_r;
    logic                 cs_nx_s;
    logic                 busy_r;
    logic                 done_r;
    logic                 ovf_r;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_dout_s;

    // A write while full is dropped even if the FSM pops in the same cycle.
    assign push_s = TX_En & ~fifo_full_s;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .push  (push_s),
        .pop   (pop_s),
        .din   (TX_Data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Frame sequencing; outputs are decoded from the next state so they register in step.
    always_comb begin
        state_nx_s    = state_r;
        shift_nx_s    = shift_r;
        bit_cnt_nx_s  = bit_cnt_r;
        stop_cnt_nx_s = stop_cnt_r;
        pop_s         = 1'b0;
`ifdef TX_PARITY_EN
        parity_nx_s   = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s         = 1'b1;
                    state_nx_s    = START;
                    bit_cnt_nx_s  = 3'd0;
                    stop_cnt_nx_s = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                // FIFO read data lands one cycle into START and is held from then on.
                shift_nx_s = fifo_dout_s;
`ifdef TX_PARITY_EN
                parity_nx_s = even_parity(fifo_dout_s);
`endif
                if (BPS_CLK) begin
                    state_nx_s = DATA;
                end else begin
                    state_nx_s = START;
                end
            end
            DATA: begin
                if (BPS_CLK) begin
                    shift_nx_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_nx_s = 3'd0;
`ifdef TX_PARITY_EN
                        state_nx_s   = PARITY;
`else
                        state_nx_s   = STOP;
`endif
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_nx_s = DATA;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (BPS_CLK) begin
                    state_nx_s = STOP;
                end else begin
                    state_nx_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (BPS_CLK) begin
                    if (stop_cnt_r == LAST_STOP) begin
                        stop_cnt_nx_s = 1'b0;
                        state_nx_s    = DONE;
                    end else begin
                        stop_cnt_nx_s = stop_cnt_r + 1'b1;
                    end
                end else begin
                    state_nx_s = STOP;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase

        pin_nx_s = 1'b1;
        cs_nx_s  = 1'b0;
        case (state_nx_s)
            START: begin
                pin_nx_s = 1'b0;
                cs_nx_s  = 1'b1;
            end
            DATA: begin
                pin_nx_s = shift_nx_s[0];
                cs_nx_s  = 1'b1;
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                pin_nx_s = parity_nx_s;
                cs_nx_s  = 1'b1;
            end
`endif
            STOP: begin
                pin_nx_s = 1'b1;
                cs_nx_s  = 1'b1;
            end
            default: begin
                pin_nx_s = 1'b1;
                cs_nx_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
`ifdef TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
            pin_r      <= 1'b1;
            cs_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            shift_r    <= shift_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
            stop_cnt_r <= stop_cnt_nx_s;
`ifdef TX_PARITY_EN
            parity_r   <= parity_nx_s;
`endif
            pin_r      <= pin_nx_s;
            cs_r       <= cs_nx_s;
            busy_r     <= (state_nx_s != IDLE);
            done_r     <= (state_nx_s == DONE);
            ovf_r      <= TX_En & fifo_full_s;
        end
    end

    assign TX_Rdy     = ~fifo_full_s;
    assign TX_Ovf     = ovf_r;
    assign Count_Sig  = cs_r;
    assign TX_Pin_Out = pin_r;
    assign TX_Busy    = busy_r;
    assign TX_Done    = done_r;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed self-checking bench for tx_frame_ctrl with a 100-count baud generator
// model; a second instance is built with STOP_BITS=2.
module tb_tx_frame_ctrl;

`ifdef TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int STOP_IDX  = 851 + 100 * PAR;
    localparam int DONE_IDX  = STOP_IDX + 100;
    localparam int FRAME_LEN = DONE_IDX + 2;
    localparam int DONE2_IDX = STOP_IDX + 200;
    localparam int CAP_MAX   = 5600;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       tx_en1, tx_en2;
    logic [7:0] tx_data1, tx_data2;
    logic       rdy1, ovf1, cs1, pin1, busy1, done1, bps1;
    logic       rdy2, ovf2, cs2, pin2, busy2, done2, bps2;
    logic [6:0] cnt1, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    logic line_a [CAP_MAX];
    logic done_a [CAP_MAX];
    logic cs_a   [CAP_MAX];
    logic busy_a [CAP_MAX];

    always #5 CLK = ~CLK;

    tx_frame_ctrl #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .TX_En(tx_en1), .TX_Data(tx_data1),
        .TX_Rdy(rdy1), .TX_Ovf(ovf1), .BPS_CLK(bps1), .Count_Sig(cs1),
        .TX_Pin_Out(pin1), .TX_Busy(busy1), .TX_Done(done1)
    );

    tx_frame_ctrl #(.FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .CLK(CLK), .RSTn(RSTn), .TX_En(tx_en2), .TX_Data(tx_data2),
        .TX_Rdy(rdy2), .TX_Ovf(ovf2), .BPS_CLK(bps2), .Count_Sig(cs2),
        .TX_Pin_Out(pin2), .TX_Busy(busy2), .TX_Done(done2)
    );

    // Baud generator model: counts 0..99 while enabled, strobes at count 50.
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt1 <= 7'd0;
            cnt2 <= 7'd0;
        end else begin
            cnt1 <= (!cs1 || cnt1 == 7'd99) ? 7'd0 : cnt1 + 7'd1;
            cnt2 <= (!cs2 || cnt2 == 7'd99) ? 7'd0 : cnt2 + 7'd1;
        end
    end
    assign bps1 = (cnt1 == 7'd50);
    assign bps2 = (cnt2 == 7'd50);

    // Records ncyc samples starting at the first low line sample (index 0 = first START cycle).
    task automatic capture(input int sel, input int ncyc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (((sel == 0) ? pin1 : pin2) === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL capture_start: no start bit on dut%0d within 3000 cycles", sel + 1);
        end else begin
            for (int i = 0; i < ncyc; i++) begin
                if (i > 0) @(negedge CLK);
                line_a[i] = (sel == 0) ? pin1  : pin2;
                done_a[i] = (sel == 0) ? done1 : done2;
                cs_a[i]   = (sel == 0) ? cs1   : cs2;
                busy_a[i] = (sel == 0) ? busy1 : busy2;
            end
        end
    endtask

    // Reads data bits at mid-bit of a frame whose START begins at base.
    function automatic logic [7:0] decode(input int base);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = line_a[base + 101 + 100 * k];
        return d;
    endfunction

    task automatic wr1(input logic [7:0] d);
        @(negedge CLK);
        tx_en1   = 1'b1;
        tx_data1 = d;
        @(negedge CLK);
        tx_en1   = 1'b0;
    endtask

    task automatic test_reset;
        RSTn = 1'b1;
        #3;
        RSTn = 1'b0;
        #4;
        n_checks++; if (pin1 !== 1'b1) begin n_fail++; $display("FAIL reset_pin: got %b expected 1", pin1); end
        n_checks++; if (cs1 !== 1'b0) begin n_fail++; $display("FAIL reset_count_sig: got %b expected 0", cs1); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done1); end
        n_checks++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf1); end
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", rdy1); end
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_single_byte;
        logic [7:0] d;
        int run, bad, pulses;
        d = 8'h55;
        wr1(d);
        capture(0, DONE_IDX + 6);
        run = 0;
        while (run < 200 && line_a[run] === 1'b0) run++;
        n_checks++; if (run != 51) begin n_fail++; $display("FAIL single_start_len: got %0d cycles expected 51", run); end
        for (int k = 0; k < 8; k++) begin
            bad = 0;
            for (int j = 0; j < 100; j++) if (line_a[51 + 100 * k + j] !== d[k]) bad++;
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_bit%0d: %0d of 100 cycles differ from expected %b", k, bad, d[k]); end
        end
        bad = 0;
        for (int j = 0; j < 100; j++) if (line_a[STOP_IDX + j] !== 1'b1) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_stop: %0d of 100 cycles not high", bad); end
        n_checks++; if (done_a[DONE_IDX] !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1 at idx %0d", done_a[DONE_IDX], DONE_IDX); end
        pulses = 0;
        for (int i = 0; i < DONE_IDX + 6; i++) if (done_a[i] === 1'b1) pulses++;
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_done_width: got %0d cycles expected 1", pulses); end
        n_checks++; if (cs_a[DONE_IDX - 1] !== 1'b1) begin n_fail++; $display("FAIL single_cs_stop: got %b expected 1", cs_a[DONE_IDX - 1]); end
        n_checks++; if (cs_a[DONE_IDX] !== 1'b0) begin n_fail++; $display("FAIL single_cs_done: got %b expected 0", cs_a[DONE_IDX]); end
        n_checks++; if (line_a[DONE_IDX] !== 1'b1) begin n_fail++; $display("FAIL single_line_done: got %b expected 1", line_a[DONE_IDX]); end
        n_checks++; if (busy_a[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy_start: got %b expected 1", busy_a[0]); end
        n_checks++; if (busy_a[DONE_IDX + 1] !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", busy_a[DONE_IDX + 1]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [4];
        logic [7:0] got;
        int pulses, b;
        exp_b = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
        fork
            capture(0, 4 * FRAME_LEN);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge CLK);
                    tx_en1   = 1'b1;
                    tx_data1 = exp_b[i];
                end
                @(negedge CLK);
                tx_en1 = 1'b0;
            end
        join
        for (int f = 0; f < 4; f++) begin
            b = f * FRAME_LEN;
            got = decode(b);
            n_checks++; if (got !== exp_b[f]) begin n_fail++; $display("FAIL burst_byte%0d: got %h expected %h", f, got, exp_b[f]); end
            n_checks++; if (done_a[b + DONE_IDX] !== 1'b1) begin n_fail++; $display("FAIL burst_done%0d: got %b expected 1", f, done_a[b + DONE_IDX]); end
            n_checks++;
            if (line_a[b + DONE_IDX] !== 1'b1 || line_a[b + DONE_IDX + 1] !== 1'b1 || cs_a[b + DONE_IDX + 1] !== 1'b0) begin
                n_fail++; $display("FAIL burst_gap%0d: line %b%b cs %b expected line 11 cs 0", f, line_a[b + DONE_IDX], line_a[b + DONE_IDX + 1], cs_a[b + DONE_IDX + 1]);
            end
            if (f < 3) begin
                n_checks++; if (line_a[b + FRAME_LEN] !== 1'b0) begin n_fail++; $display("FAIL burst_next_start%0d: got %b expected 0", f, line_a[b + FRAME_LEN]); end
            end
        end
        pulses = 0;
        for (int i = 0; i < 4 * FRAME_LEN; i++) if (done_a[i] === 1'b1) pulses++;
        n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL burst_done_count: got %0d expected 4", pulses); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_b [5];
        logic [7:0] got;
        bit found;
        int lows, pulses;
        exp_b = '{8'h12, 8'h11, 8'h22, 8'h33, 8'h44};
        wr1(8'h12);
        fork
            capture(0, 5 * FRAME_LEN + 200);
            begin
                found = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge CLK);
                    if (bps1 === 1'b1) begin found = 1'b1; break; end
                end
                n_checks++; if (!found) begin n_fail++; $display("FAIL ovf_bps_wait: no BPS_CLK within 300 cycles"); end
                // First write lands on the same edge as a bit strobe.
                tx_en1 = 1'b1; tx_data1 = 8'h11;
                @(negedge CLK); tx_data1 = 8'h22;
                @(negedge CLK); tx_data1 = 8'h33;
                @(negedge CLK);
                n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL ovf_rdy_3: got %b expected 1", rdy1); end
                tx_data1 = 8'h44;
                @(negedge CLK);
                n_checks++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy_4: got %b expected 0", rdy1); end
                n_checks++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", ovf1); end
                tx_data1 = 8'h99;
                @(negedge CLK);
                tx_en1 = 1'b0;
                n_checks++; if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b expected 1", ovf1); end
                @(negedge CLK);
                n_checks++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL ovf_width: got %b expected 0", ovf1); end
            end
        join
        for (int f = 0; f < 5; f++) begin
            got = decode(f * FRAME_LEN);
            n_checks++; if (got !== exp_b[f]) begin n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", f, got, exp_b[f]); end
        end
        n_checks++; if (done_a[DONE_IDX] !== 1'b1) begin n_fail++; $display("FAIL ovf_frame0_timing: done %b expected 1 at idx %0d", done_a[DONE_IDX], DONE_IDX); end
        lows = 0;
        for (int i = 5 * FRAME_LEN; i < 5 * FRAME_LEN + 200; i++) if (line_a[i] !== 1'b1 || cs_a[i] !== 1'b0) lows++;
        n_checks++; if (lows != 0) begin n_fail++; $display("FAIL ovf_no_sixth: %0d active cycles after frame 5 expected 0", lows); end
        pulses = 0;
        for (int i = 0; i < 5 * FRAME_LEN + 200; i++) if (done_a[i] === 1'b1) pulses++;
        n_checks++; if (pulses != 5) begin n_fail++; $display("FAIL ovf_done_count: got %0d expected 5", pulses); end
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL ovf_rdy_end: got %b expected 1", rdy1); end
    endtask

    task automatic test_parity;
        logic [7:0] vals [2];
        logic [7:0] got;
        logic       exp_p;
        vals = '{8'h07, 8'h03};
        for (int v = 0; v < 2; v++) begin
            wr1(vals[v]);
            capture(0, DONE_IDX + 5);
            got   = decode(0);
            exp_p = (PAR == 1) ? ^vals[v] : 1'b1;
            n_checks++; if (got !== vals[v]) begin n_fail++; $display("FAIL parity_byte%0d: got %h expected %h", v, got, vals[v]); end
            n_checks++; if (line_a[901] !== exp_p) begin n_fail++; $display("FAIL parity_bit%0d: got %b expected %b", v, line_a[901], exp_p); end
            n_checks++; if (done_a[DONE_IDX] !== 1'b1) begin n_fail++; $display("FAIL parity_len%0d: done %b expected 1 at idx %0d", v, done_a[DONE_IDX], DONE_IDX); end
        end
    endtask

    task automatic test_reset_mid_frame;
        bit found;
        int active;
        @(negedge CLK); tx_en1 = 1'b1; tx_data1 = 8'h81;
        @(negedge CLK); tx_data1 = 8'h5A;
        @(negedge CLK); tx_en1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (pin1 === 1'b0) found = 1'b1;
            else @(negedge CLK);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rst_mid_start: no start bit within 50 cycles"); end
        repeat (401) @(negedge CLK);
        n_checks++; if (pin1 !== 1'b0 || cs1 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_bit3: line %b cs %b expected line 0 cs 1", pin1, cs1); end
        #2;
        RSTn = 1'b0;
        #1;
        n_checks++; if (pin1 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pin: got %b expected 1", pin1); end
        n_checks++; if (cs1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cs: got %b expected 0", cs1); end
        n_checks++; if (busy1 !== 1'b0 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags: busy %b rdy %b expected busy 0 rdy 1", busy1, rdy1); end
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        active = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            if (pin1 !== 1'b1 || cs1 !== 1'b0 || busy1 !== 1'b0) active++;
        end
        n_checks++; if (active != 0) begin n_fail++; $display("FAIL rst_mid_no_resume: %0d active cycles after release expected 0", active); end
    endtask

    task automatic test_stop2;
        logic [7:0] got;
        int bad;
        @(negedge CLK); tx_en2 = 1'b1; tx_data2 = 8'hC3;
        @(negedge CLK); tx_en2 = 1'b0;
        capture(1, DONE2_IDX + 5);
        got = decode(0);
        n_checks++; if (got !== 8'hC3) begin n_fail++; $display("FAIL stop2_byte: got %h expected c3", got); end
        bad = 0;
        for (int j = 0; j < 200; j++) if (line_a[STOP_IDX + j] !== 1'b1) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stop2_high: %0d of 200 cycles not high", bad); end
        n_checks++; if (cs_a[DONE2_IDX - 1] !== 1'b1) begin n_fail++; $display("FAIL stop2_cs: got %b expected 1", cs_a[DONE2_IDX - 1]); end
        n_checks++; if (done_a[DONE2_IDX - 1] !== 1'b0 || done_a[DONE2_IDX] !== 1'b1) begin
            n_fail++; $display("FAIL stop2_done: got %b%b expected 01", done_a[DONE2_IDX - 1], done_a[DONE2_IDX]);
        end
    endtask

    initial begin
        tx_en1 = 1'b0; tx_data1 = 8'h00;
        tx_en2 = 1'b0; tx_data2 = 8'h00;
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_overflow;
        test_parity;
        test_reset_mid_frame;
        test_stop2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
